intr_controller: RTL

INTR_CONTROLLER -- requirements
Module: intr_controller

---
 rtl/intr_controller.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/intr_controller.sv
// Edge-triggered interrupt controller: mask/pending/status registers on a simple bus and a one-at-a-time request FSM.
// Latency: an irqIn rising edge is pending 1 cycle later; intr rises 2 cycles after the edge (or after the EOI edge).
// Backpressure: none. Bus accesses are always accepted, and new requests stay pending until the current service ends.
module intr_controller #(
  parameter int               BITS      = 32,
  parameter int               NUM_SRC   = 4,
  parameter logic [BITS-1:0]  MASK_BASE = BITS'(32'hF0000800),
  parameter logic [BITS-1:0]  PEND_BASE = BITS'(32'hF0000804),
  parameter logic [BITS-1:0]  STAT_BASE = BITS'(32'hF0000808)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic               re,
  input  logic [BITS-1:0]    memAddr,
  input  logic [BITS-1:0]    dataBusIn,
  output logic [BITS-1:0]    dataBusOut,
  input  logic [NUM_SRC-1:0] irqIn,
  output logic               intr,
  input  logic               intAck,
  output logic [2:0]         intVec
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    INSVC = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] pend_nxt;
  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] req_vec;
  logic [NUM_SRC-1:0] id_onehot;
  logic [2:0]         cur_id;
  logic [2:0]         lowest_id;
  logic               edge_en;
  logic               latch_id;
  logic               ack_clr;
  logic               mask_wr;
  logic               pend_wr;
  logic               eoi_wr;
  logic               unused_din;

  assign mask_wr    = we && (memAddr == MASK_BASE);
  assign pend_wr    = we && (memAddr == PEND_BASE);
  assign eoi_wr     = we && (memAddr == STAT_BASE);
  assign req_vec    = pending & mask;
  // Only the low NUM_SRC data bits are architecturally meaningful.
  assign unused_din = ^dataBusIn;

  // Pick the lowest-index enabled pending source.
  always_comb begin
    lowest_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_vec[i]) lowest_id = i[2:0];
    end
  end

  // One-hot of the source being serviced, used to clear its pending bit on ack.
  always_comb begin
    id_onehot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cur_id == i[2:0]) id_onehot[i] = 1'b1;
    end
  end

  // Pending next-value: W1C writes and ack clears, with a fresh rising edge always winning.
  // edge_en stays low for the first cycle after reset so a level held through reset is not seen as an edge.
  always_comb begin
    rise = irqIn & ~irq_q & {NUM_SRC{edge_en}};
    clr  = '0;
    if (pend_wr) clr = dataBusIn[NUM_SRC-1:0];
    if (ack_clr) clr = clr | id_onehot;
    pend_nxt = (pending & ~clr) | rise;
  end

  // Input sampling, mask and pending registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q   <= '0;
      edge_en <= 1'b0;
      mask    <= '0;
      pending <= '0;
    end else begin
      irq_q   <= irqIn;
      edge_en <= 1'b1;
      pending <= pend_nxt;
      if (mask_wr) mask <= dataBusIn[NUM_SRC-1:0];
    end
  end

  // FSM state and the latched source ID; cur_id only changes when leaving IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cur_id <= '0;
    end else begin
      state <= state_nxt;
      if (latch_id) cur_id <= lowest_id;
    end
  end

  // Next-state and request outputs; outputs are forced low while reset is asserted.
  always_comb begin
    state_nxt = state;
    latch_id  = 1'b0;
    ack_clr   = 1'b0;
    intr      = 1'b0;
    intVec    = '0;
    case (state)
      IDLE: begin
        if (|req_vec) begin
          latch_id  = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        intr   = 1'b1;
        intVec = cur_id;
        if (intAck) begin
          ack_clr   = 1'b1;
          state_nxt = INSVC;
        end
      end
      INSVC: begin
        intVec = cur_id;
        if (eoi_wr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      intr   = 1'b0;
      intVec = '0;
    end
  end

  // Combinational read mux; zero unless a clean read hits one of the three registers.
  always_comb begin
    dataBusOut = '0;
    if (re && !we && !reset) begin
      if (memAddr == MASK_BASE) begin
        dataBusOut[NUM_SRC-1:0] = mask;
      end else if (memAddr == PEND_BASE) begin
        dataBusOut[NUM_SRC-1:0] = pending;
      end else if (memAddr == STAT_BASE) begin
        dataBusOut[2:0] = cur_id;
        dataBusOut[3]   = (state == REQ);
        dataBusOut[4]   = (state == INSVC);
      end
    end
  end

endmodule
